// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared channel layout and colour-code constants for the RGB decoder
package rgb_pkg;

  typedef logic [7:0] ch_t;
  typedef logic [2:0] colour_t;

  // Channel bit positions inside a 24-bit pixel
  localparam int RED_HI = 23;
  localparam int RED_LO = 16;
  localparam int GRN_HI = 15;
  localparam int GRN_LO = 8;
  localparam int BLU_HI = 7;
  localparam int BLU_LO = 0;

  // The only channel values the colour converter ever produces
  localparam ch_t CH_MIN = 8'h00;
  localparam ch_t CH_MAX = 8'hFF;

  // Colour-code bit indices
  localparam int COL_R = 2;
  localparam int COL_G = 1;
  localparam int COL_B = 0;

endpackage

// File: rtl/rgb_channel_quant.sv
// rtl/rgb_channel_quant.sv - combinational threshold and exactness test for one colour channel
module rgb_channel_quant
  import rgb_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd128
) (
  input  ch_t  ch_i,
  output logic bit_o,
  output logic exact_o
);

  // A channel at or above the threshold reads as "on"
  assign bit_o   = (ch_i >= THRESH);
  // Only fully-off or fully-on channels can come straight out of the converter
  assign exact_o = (ch_i == CH_MIN) || (ch_i == CH_MAX);

endmodule

// File: rtl/rgb_decoder.sv
// rtl/rgb_decoder.sv - two-stage RGB to 3-bit colour decoder with non-exact pixel counter
module rgb_decoder
  import rgb_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd128,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_rgb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_colour,
  output logic             out_exact,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  colour_t          cmp_bits;
  logic [2:0]       exact_bits;
  logic             adv;
  logic             accept;

  logic             s1_valid_q, s1_valid_d;
  colour_t          s1_col_q, s1_col_d;
  logic [2:0]       s1_ex_q, s1_ex_d;
  logic             s2_valid_q, s2_valid_d;
  colour_t          out_colour_q, out_colour_d;
  logic             out_exact_q, out_exact_d;
  logic [CNT_W-1:0] err_q, err_d;

  rgb_channel_quant #(.THRESH(THRESH)) u_red (
    .ch_i    (in_rgb[RED_HI:RED_LO]),
    .bit_o   (cmp_bits[COL_R]),
    .exact_o (exact_bits[COL_R])
  );

  rgb_channel_quant #(.THRESH(THRESH)) u_grn (
    .ch_i    (in_rgb[GRN_HI:GRN_LO]),
    .bit_o   (cmp_bits[COL_G]),
    .exact_o (exact_bits[COL_G])
  );

  rgb_channel_quant #(.THRESH(THRESH)) u_blu (
    .ch_i    (in_rgb[BLU_HI:BLU_LO]),
    .bit_o   (cmp_bits[COL_B]),
    .exact_o (exact_bits[COL_B])
  );

  // The whole pipeline moves together whenever the output slot can be vacated
  assign adv        = !s2_valid_q || out_ready;
  // Held low during reset so nothing is accepted before the first clean edge
  assign in_ready   = rst_n && adv && enable;
  assign accept     = in_valid && in_ready;
  assign out_valid  = s2_valid_q;
  assign out_colour = out_colour_q;
  assign out_exact  = out_exact_q;
  assign err_count  = err_q;

  // Next-state for both pipeline stages and the saturating non-exact counter
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_col_d     = s1_col_q;
    s1_ex_d      = s1_ex_q;
    s2_valid_d   = s2_valid_q;
    out_colour_d = out_colour_q;
    out_exact_d  = out_exact_q;
    err_d        = err_q;

    if (adv) begin
      s1_valid_d   = accept;
      if (accept) begin
        s1_col_d = cmp_bits;
        s1_ex_d  = exact_bits;
      end
      s2_valid_d   = s1_valid_q;
      out_colour_d = s1_col_q;
      out_exact_d  = &s1_ex_q;
    end

    if (cnt_clear) begin
      err_d = '0;
    end else if (s2_valid_q && out_ready && !out_exact_q && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_ONE;
    end
  end

  // Pipeline and counter registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_col_q     <= '0;
      s1_ex_q      <= '0;
      s2_valid_q   <= 1'b0;
      out_colour_q <= '0;
      out_exact_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_col_q     <= s1_col_d;
      s1_ex_q      <= s1_ex_d;
      s2_valid_q   <= s2_valid_d;
      out_colour_q <= out_colour_d;
      out_exact_q  <= out_exact_d;
      err_q        <= err_d;
    end
  end

endmodule
